ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction-fetch initiator that drives the read side of instr_ram. It owns the fetch PC, turns it into a RAM word address, captures the returned instruction word, and presents {pc, instr} to decode over a valid/ready handshake. A 2-entry buffer absorbs decode stalls. Redirect (branch/jump/trap) flushes the buffer and restarts fetch; halt freezes issue. The block never writes the RAM.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] forced to 0.
BUF_DEPTH, 2, output buffer entries; only 2 is supported (assert at elaboration).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
ram_we  output  1  instr_ram write enable; constant 0
ram_address  output  32  instr_ram word address = {2'b00, fetch_pc[31:2]}
ram_wdata  output  32  constant 0
ram_rdata  input  32  instr_ram read data; combinational from ram_address, valid in the same cycle
redirect_valid  input  1  one-cycle request to restart fetch
redirect_pc  input  32  new PC; bits [1:0] ignored
halt  input  1  level; while high, no new fetches are issued
instr_valid  output  1  buffer head holds a valid instruction
instr_ready  input  1  decode accepts head this cycle
instr_data  output  32  instruction word at head
instr_pc  output  32  byte PC of instr_data

Behaviour:
- Synchronous, active-low reset: rst_n sampled only on the clk edge. While rst_n=0 at an edge: fetch_pc<=RESET_PC, buffer emptied, state<=FETCH. Outputs under reset: instr_valid=0, instr_data=0, instr_pc=0, ram_address={2'b00, RESET_PC[31:2]}, ram_we=0, ram_wdata=0.
- Reset asserted mid-stream drops all buffered entries; no partial handshake survives.
- Buffer: 2-entry FIFO of {pc, data}; count 0..2; head drives instr_*; instr_data and instr_pc = 0 when empty.
- pop = instr_valid & instr_ready.
- push = (state==FETCH) & ~redirect_valid & (count<2 | pop). Push stores {fetch_pc, ram_rdata}; fetch_pc <= fetch_pc + 4, mod 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
- Simultaneous push and pop at count 2: legal; count stays 2; order is preserved.
- Latency: fetch_pc is presented at cycle N; the entry is visible on instr_* at cycle N+1.
- Sustained throughput is 1 instruction/cycle with instr_ready held high.
- Redirect has priority over push, pop and halt. On a redirect edge:
  - buffer flushed (count<=0, any same-cycle pop is discarded);
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; no push that cycle;
  - instr_valid=0 the next cycle; the first redirected instruction appears 2 cycles after the redirect edge.
- State machine:
  - FETCH: issue/push as above. Go to STALL when count==2 and ~pop. Go to HALT when halt=1.
  - STALL: no push; ram_address held. Return to FETCH when pop occurs or count<2. Go to HALT when halt=1.
  - HALT: no push; buffered entries still drain via pop. Return to FETCH when halt=0.
  - A redirect in any state loads the PC and flushes the buffer; the state follows halt (HALT if halt=1, else FETCH).
- instr_valid never drops while count>0 and no redirect occurs. instr_data and instr_pc are stable while valid & ~ready.

Decomposition:
- Shared package riscv_pkg:
  - XLEN=32;
  - INSTR_NOP=32'h0000_0013;
  - fetch_state_t enum {FETCH, STALL, HALT};
  - fetch_entry_t struct {pc, data}.
- Sub-module fetch_buf: 2-entry synchronous FIFO with push/pop/flush, count, head outputs and sync active-low reset. ifetch_unit holds the PC, the FSM and the RAM interface.

Test Plan:
- Reset, then RAM words 0:0x11, 1:0x22, 2:0x33 with instr_ready=1 -> from cycle 1 after reset, (pc,data) = (0,0x11), (4,0x22), (8,0x33) on consecutive cycles; ram_we stays 0.
- instr_ready=0 for 5 cycles after the first valid -> head holds (0,0x11), count reaches 2, ram_address frozen at 2. Release ready -> outputs 0x11, 0x22, 0x33 in order with no gap and no duplicate.
- redirect_valid with redirect_pc=0x0000_0103 while 2 entries are buffered -> next cycle instr_valid=0, then (0x100, mem[0x40]); no stale entry is emitted.
- Redirect and pop in the same cycle -> the popped entry is consumed exactly once; the flush wins, and no further old-stream entry appears.
- RESET_PC=32'hFFFF_FFF8 -> pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap); ram_address 0x3FFF_FFFE, 0x3FFF_FFFF, 0x0.
- halt=1 for 4 cycles with ready=1 -> buffer drains, then instr_valid=0 and fetch_pc is held. halt=0 -> fetch resumes at the held PC. rst_n=0 for one edge mid-stream -> next cycle instr_valid=0 and ram_address=RESET_PC>>2.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: datapath width, fetch FSM states,
// buffered fetch entry layout and small PC helpers.
package riscv_pkg;

    localparam int XLEN = 32;

    // Canonical RISC-V no-op (addi x0, x0, 0).
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // One buffered instruction: the byte PC it was fetched from and the word.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_ZERO = '{pc: 32'h0000_0000, data: 32'h0000_0000};

    // Clear the two byte-offset bits; fetch only ever works on whole words.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

    // Byte PC to instr_ram word address.
    function automatic logic [XLEN-1:0] word_address(input logic [XLEN-1:0] pc);
        return pc >> 2;
    endfunction

    // Sequential next PC; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order buffer of fetched instructions.
// Slot 0 is always the head; slot 1 shifts down on a pop. Empty slots are
// held at zero so the head outputs read as zero when nothing is buffered.
module fetch_buf
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_entry,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head
);

    logic [1:0]   count_r;
    logic [1:0]   count_nxt_s;
    fetch_entry_t slot0_r;
    fetch_entry_t slot1_r;
    fetch_entry_t slot0_nxt_s;
    fetch_entry_t slot1_nxt_s;
    logic         do_push_s;
    logic         do_pop_s;

    // Qualify requests: never pop an empty buffer, never overfill a full one.
    always_comb begin
        do_pop_s  = pop & (count_r != 2'd0);
        do_push_s = push & ((count_r != 2'd2) | do_pop_s);
    end

    // Next slot contents and occupancy; flush beats every other request.
    always_comb begin
        slot0_nxt_s = slot0_r;
        slot1_nxt_s = slot1_r;
        count_nxt_s = count_r;
        if (flush) begin
            slot0_nxt_s = ENTRY_ZERO;
            slot1_nxt_s = ENTRY_ZERO;
            count_nxt_s = 2'd0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b11: begin
                    // Occupancy unchanged; the new entry goes behind the survivor.
                    if (count_r == 2'd1) begin
                        slot0_nxt_s = push_entry;
                    end else begin
                        slot0_nxt_s = slot1_r;
                        slot1_nxt_s = push_entry;
                    end
                end
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_nxt_s = push_entry;
                    end else begin
                        slot1_nxt_s = push_entry;
                    end
                    count_nxt_s = count_r + 2'd1;
                end
                2'b01: begin
                    slot0_nxt_s = slot1_r;
                    slot1_nxt_s = ENTRY_ZERO;
                    count_nxt_s = count_r - 2'd1;
                end
                default: begin
                    slot0_nxt_s = slot0_r;
                    slot1_nxt_s = slot1_r;
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // Buffer state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot0_r <= ENTRY_ZERO;
            slot1_r <= ENTRY_ZERO;
            count_r <= 2'd0;
        end else begin
            slot0_r <= slot0_nxt_s;
            slot1_r <= slot1_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    assign count      = count_r;
    assign head_valid = (count_r != 2'd0);
    assign head       = slot0_r;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, reads instr_ram
// combinationally, and hands {pc, instr} to decode through a two-entry
// buffer with a valid/ready handshake. Redirect flushes and restarts fetch;
// halt stops new fetches while the buffer drains. The RAM is never written.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ram_we,
    output logic [31:0] ram_address,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    // The buffer is a fixed two-slot structure; other depths are rejected.
    if (BUF_DEPTH != 2) begin : g_bad_depth
        $error("ifetch_unit: BUF_DEPTH must be 2");
    end

    localparam logic [1:0]      ST_FETCH   = FETCH;
    localparam logic [1:0]      ST_STALL   = STALL;
    localparam logic [1:0]      ST_HALT    = HALT;
    localparam logic [XLEN-1:0] PC_AT_RESET = align_pc(RESET_PC);

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] fetch_pc_nxt_s;
    logic            push_s;
    logic            pop_s;
    logic [1:0]      count_s;
    logic            head_valid_s;
    fetch_entry_t    head_s;
    fetch_entry_t    push_entry_s;

    fetch_buf u_fetch_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push_s),
        .pop        (pop_s),
        .push_entry (push_entry_s),
        .count      (count_s),
        .head_valid (head_valid_s),
        .head       (head_s)
    );

    // Handshake and issue decision; a redirect suppresses this cycle's push.
    always_comb begin
        pop_s = head_valid_s & instr_ready;
        if ((state_r == ST_FETCH) && !redirect_valid &&
            ((count_s != 2'd2) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        push_entry_s.pc   = fetch_pc_r;
        push_entry_s.data = ram_rdata;
    end

    // Fetch FSM next state; redirect overrides and lands according to halt.
    always_comb begin
        state_nxt_s = state_r;
        if (redirect_valid) begin
            state_nxt_s = halt ? ST_HALT : ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (halt) begin
                        state_nxt_s = ST_HALT;
                    end else if ((count_s == 2'd2) && !pop_s) begin
                        state_nxt_s = ST_STALL;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
                ST_STALL: begin
                    if (halt) begin
                        state_nxt_s = ST_HALT;
                    end else if (pop_s || (count_s != 2'd2)) begin
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_STALL;
                    end
                end
                ST_HALT: begin
                    if (halt) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
                default: begin
                    state_nxt_s = ST_FETCH;
                end
            endcase
        end
    end

    // Next fetch PC: redirect target, sequential advance on push, else hold.
    always_comb begin
        if (redirect_valid) begin
            fetch_pc_nxt_s = align_pc(redirect_pc);
        end else if (push_s) begin
            fetch_pc_nxt_s = next_pc(fetch_pc_r);
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end
    end

    // PC and FSM registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            fetch_pc_r <= PC_AT_RESET;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
        end
    end

    assign ram_we      = 1'b0;
    assign ram_wdata   = 32'h0000_0000;
    assign ram_address = word_address(fetch_pc_r);
    assign instr_valid = head_valid_s;
    assign instr_data  = head_s.data;
    assign instr_pc    = head_s.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a queue-based model.
// A second instance with RESET_PC near the top of memory checks PC wrap.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        instr_ready;
    logic        ram_we;
    logic [31:0] ram_address;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    logic        w_ram_we;
    logic [31:0] w_ram_address;
    logic [31:0] w_ram_wdata;
    logic [31:0] w_ram_rdata;
    logic        w_instr_valid;
    logic [31:0] w_instr_data;
    logic [31:0] w_instr_pc;

    logic [31:0] mem [0:255];

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] q_pc[$];
    logic [31:0] q_data[$];
    bit          m_halted;
    bit          m_stalled;

    ifetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ram_we         (ram_we),
        .ram_address    (ram_address),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk            (clk),
        .rst_n          (rst_n),
        .ram_we         (w_ram_we),
        .ram_address    (w_ram_address),
        .ram_wdata      (w_ram_wdata),
        .ram_rdata      (w_ram_rdata),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0000_0000),
        .halt           (1'b0),
        .instr_valid    (w_instr_valid),
        .instr_ready    (1'b1),
        .instr_data     (w_instr_data),
        .instr_pc       (w_instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd256) return mem[a[7:0]];
        else             return a ^ 32'hDEAD_BEEF;
    endfunction

    assign ram_rdata   = (ram_address < 32'd256) ? mem[ram_address[7:0]] : (ram_address ^ 32'hDEAD_BEEF);
    assign w_ram_rdata = (w_ram_address < 32'd256) ? mem[w_ram_address[7:0]] : (w_ram_address ^ 32'hDEAD_BEEF);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc      = 32'h0000_0000;
        q_pc.delete();
        q_data.delete();
        m_halted  = 1'b0;
        m_stalled = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic model_edge();
        bit popping, issue, was_full;
        if (!rst_n) begin
            model_reset();
        end else if (redirect_valid) begin
            q_pc.delete();
            q_data.delete();
            m_pc      = redirect_pc & ~32'h3;
            m_halted  = halt;
            m_stalled = 1'b0;
        end else begin
            popping  = instr_ready && (q_pc.size() > 0);
            was_full = (q_pc.size() == 2);
            issue    = !m_halted && !m_stalled && (!was_full || popping);
            if (popping) begin
                void'(q_pc.pop_front());
                void'(q_data.pop_front());
            end
            if (issue) begin
                q_pc.push_back(m_pc);
                q_data.push_back(mem_word(m_pc >> 2));
                m_pc = m_pc + 32'd4;
            end
            if (halt) begin
                m_halted  = 1'b1;
                m_stalled = 1'b0;
            end else if (m_halted) begin
                m_halted = 1'b0;
            end else if (m_stalled) begin
                m_stalled = !(popping || !was_full);
            end else begin
                m_stalled = was_full && !popping;
            end
        end
    endtask

    // One cycle: check outputs at negedge against the model, then clock.
    task automatic step();
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_data;
        @(negedge clk);
        e_valid = (q_pc.size() != 0);
        e_pc    = e_valid ? q_pc[0]   : 32'h0;
        e_data  = e_valid ? q_data[0] : 32'h0;
        chk("valid", {31'd0, instr_valid}, {31'd0, e_valid});
        chk("pc",    instr_pc, e_pc);
        chk("data",  instr_data, e_data);
        chk("addr",  ram_address, m_pc >> 2);
        chk("we",    {31'd0, ram_we}, 32'h0);
        chk("wdata", ram_wdata, 32'h0);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0011;
        mem[1] = 32'h0000_0022;
        mem[2] = 32'h0000_0033;

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        halt = 1'b0; instr_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step();
        chk("rst_valid", {31'd0, instr_valid}, 32'h0);
        chk("rst_addr", ram_address, 32'h0);
        chk("w_rst_addr", w_ram_address, 32'h3FFF_FFFE);
        chk("w_rst_valid", {31'd0, w_instr_valid}, 32'h0);

        // Streaming after reset, plus wrap on the second instance
        rst_n = 1'b1; instr_ready = 1'b1;
        step();
        chk("s0_pc", instr_pc, 32'h0);
        chk("s0_data", instr_data, 32'h11);
        chk("w0_pc", w_instr_pc, 32'hFFFF_FFF8);
        chk("w0_data", w_instr_data, 32'h3FFF_FFFE ^ 32'hDEAD_BEEF);
        chk("w0_addr", w_ram_address, 32'h3FFF_FFFF);
        step();
        chk("s1_pc", instr_pc, 32'h4);
        chk("s1_data", instr_data, 32'h22);
        chk("w1_pc", w_instr_pc, 32'hFFFF_FFFC);
        chk("w1_addr", w_ram_address, 32'h0);
        step();
        chk("s2_pc", instr_pc, 32'h8);
        chk("s2_data", instr_data, 32'h33);
        chk("w2_pc", w_instr_pc, 32'h0);
        chk("w2_data", w_instr_data, 32'h11);
        chk("w2_addr", w_ram_address, 32'h1);

        // Decode stall of 5 cycles after first valid
        rst_n = 1'b0; instr_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        repeat (5) step();
        chk("st_pc", instr_pc, 32'h0);
        chk("st_data", instr_data, 32'h11);
        chk("st_addr", ram_address, 32'h2);
        instr_ready = 1'b1;
        step();
        chk("rel0_data", instr_data, 32'h22);
        step();
        chk("rel1_data", instr_data, 32'h33);
        step();
        chk("rel2_pc", instr_pc, 32'hC);
        chk("rel2_data", instr_data, mem_word(32'h3));

        // Redirect with two entries buffered
        instr_ready = 1'b0;
        step();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        chk("rd_valid", {31'd0, instr_valid}, 32'h0);
        chk("rd_addr", ram_address, 32'h40);
        step();
        chk("rd_pc", instr_pc, 32'h100);
        chk("rd_data", instr_data, mem_word(32'h40));

        // Redirect coincident with a pop
        instr_ready = 1'b1;
        step();
        chk("rp_pre_pc", instr_pc, 32'h104);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        chk("rp_valid", {31'd0, instr_valid}, 32'h0);
        step();
        chk("rp_pc", instr_pc, 32'h200);

        // Halt drains the buffer and holds the PC
        halt = 1'b1;
        repeat (4) step();
        chk("h_valid", {31'd0, instr_valid}, 32'h0);
        chk("h_addr", ram_address, 32'h82);
        halt = 1'b0;
        step();
        step();
        chk("h_resume_pc", instr_pc, 32'h208);

        // Mid-stream reset for one edge
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mr_valid", {31'd0, instr_valid}, 32'h0);
        chk("mr_addr", ram_address, 32'h0);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            instr_ready    = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom_range(0, 32'h3FF);
            rst_n          = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1; redirect_valid = 1'b0; halt = 1'b0; instr_ready = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
